// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x3 key matrix scanner with frame debounce, press event and multi-key flag
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  key_col,
    input  logic [3:0]  key_row,
    output logic [11:0] button_sw,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        multi_key
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(DEBOUNCE_SCANS);
    logic [3:0]    row_meta, row_sync, part0, part1, index;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [11:0]   frame, prev_frame;
    logic [RW-1:0] run, run_next;
    logic          sample, frame_done, update, multi, single, press;
    assign sample     = dwell == DWELL_LAST;
    assign frame_done = sample && col == 2'd2;
    assign key_col    = ~(3'b001 << col);
    always_comb begin
        frame = '0;
        index = '0;
        for (int r = 0; r < 4; r++) begin
            frame[r*3]   = part0[r];
            frame[r*3+1] = part1[r];
            frame[r*3+2] = ~row_sync[r];
        end
        for (int i = 0; i < 12; i++) index = frame[i] ? 4'(i) : index;
    end
    assign run_next = frame != prev_frame ? RW'(1) : run == RUN_MAX ? run : run + 1'b1;
    assign update   = frame_done && run_next == RUN_MAX && frame != button_sw;
    assign multi    = |(frame & (frame - 12'd1));
    assign single   = |frame && !multi;
    // a press needs the lone set bit to be newly set, so 2->1 key transitions stay silent
    assign press    = update && single && |(frame & ~button_sw);
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta   <= 4'hf;
            row_sync   <= 4'hf;
            dwell      <= '0;
            col        <= '0;
            part0      <= '0;
            part1      <= '0;
            prev_frame <= '0;
            run        <= '0;
            button_sw  <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            multi_key  <= 1'b0;
        end else begin
            row_meta  <= key_row;
            row_sync  <= row_meta;
            dwell     <= sample ? '0 : dwell + 1'b1;
            key_valid <= press;
            if (sample) col <= col == 2'd2 ? 2'd0 : col + 2'd1;
            if (sample && col == 2'd0) part0 <= ~row_sync;
            if (sample && col == 2'd1) part1 <= ~row_sync;
            if (frame_done) begin
                run        <= run_next;
                prev_frame <= frame;
            end
            if (update) begin
                button_sw <= frame;
                multi_key <= multi;
            end
            if (press) key_code <= index;
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: matrix-emulating bench with frame-level debounce model
module tb_keypad_matrix_scanner;
    localparam int SD = 8;
    localparam int DB = 3;
    localparam int FRAME = 3 * SD;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  key_col;
    logic [3:0]  key_row;
    logic [11:0] button_sw;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        multi_key;
    logic [11:0] pressed = '0;
    int checks = 0;
    int errors = 0;
    logic [11:0] m_prev, m_sw;
    int          m_run, m_pulse;
    logic [3:0]  m_code;
    typedef struct {
        logic [11:0] keys;
        logic [11:0] sw;
        int          pulses;
        logic [3:0]  code;
        logic        multi;
    } vec_t;
    vec_t vecs[18];

    keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
        .button_sw(button_sw), .key_valid(key_valid), .key_code(key_code), .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    // physical matrix: a pressed key shorts its row to a column that is driven low
    always_comb begin
        key_row = 4'hf;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_sw = '0; m_run = 0; m_code = '0; m_pulse = 0;
    endtask

    task automatic model_frame(input logic [11:0] keys);
        m_run = (keys == m_prev) ? ((m_run + 1 > DB) ? DB : m_run + 1) : 1;
        m_prev = keys;
        m_pulse = 0;
        if (m_run >= DB && keys != m_sw) begin
            if ($countones(keys) == 1 && (keys & ~m_sw) != 0) begin
                m_pulse = 1;
                for (int i = 0; i < 12; i++) if (keys[i]) m_code = 4'(i);
            end
            m_sw = keys;
        end
    endtask

    // holds keys for one full frame, counts key_valid pulses, ends #1 after frame-complete edge
    task automatic run_frame(input logic [11:0] keys, output int pulses);
        pressed = keys;
        pulses = 0;
        repeat (FRAME) begin
            @(posedge clk);
            #1;
            if (key_valid) pulses++;
        end
    endtask

    initial begin
        int p;
        logic [11:0] k;
        vecs[0]  = '{12'h080, 12'h000, 0, 4'd0, 1'b0};
        vecs[1]  = '{12'h080, 12'h000, 0, 4'd0, 1'b0};
        vecs[2]  = '{12'h080, 12'h080, 1, 4'd7, 1'b0};
        vecs[3]  = '{12'h080, 12'h080, 0, 4'd7, 1'b0};
        vecs[4]  = '{12'h000, 12'h080, 0, 4'd7, 1'b0};
        vecs[5]  = '{12'h000, 12'h080, 0, 4'd7, 1'b0};
        vecs[6]  = '{12'h000, 12'h000, 0, 4'd7, 1'b0};
        vecs[7]  = '{12'h001, 12'h000, 0, 4'd7, 1'b0};
        vecs[8]  = '{12'h000, 12'h000, 0, 4'd7, 1'b0};
        vecs[9]  = '{12'h001, 12'h000, 0, 4'd7, 1'b0};
        vecs[10] = '{12'h001, 12'h000, 0, 4'd7, 1'b0};
        vecs[11] = '{12'h001, 12'h001, 1, 4'd0, 1'b0};
        vecs[12] = '{12'h801, 12'h001, 0, 4'd0, 1'b0};
        vecs[13] = '{12'h801, 12'h001, 0, 4'd0, 1'b0};
        vecs[14] = '{12'h801, 12'h801, 0, 4'd0, 1'b1};
        vecs[15] = '{12'h001, 12'h801, 0, 4'd0, 1'b1};
        vecs[16] = '{12'h001, 12'h801, 0, 4'd0, 1'b1};
        vecs[17] = '{12'h001, 12'h001, 0, 4'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_col", 32'(key_col), 32'b110);
        chk("reset_sw", 32'(button_sw), 0);
        rst = 1'b0;
        model_reset();
        for (int cyc = 1; cyc <= FRAME; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 7 || cyc == 24) chk($sformatf("col_c%0d", cyc), 32'(key_col), 32'b110);
            if (cyc == 8 || cyc == 15) chk($sformatf("col_c%0d", cyc), 32'(key_col), 32'b101);
            if (cyc == 16 || cyc == 23) chk($sformatf("col_c%0d", cyc), 32'(key_col), 32'b011);
            if (button_sw != 0 || key_valid || key_code != 0 || multi_key)
                chk("idle_outputs", {button_sw, key_code, key_valid, multi_key}, 0);
        end
        chk("idle_sw", 32'(button_sw), 0);
        model_frame(12'h000);

        foreach (vecs[i]) begin
            run_frame(vecs[i].keys, p);
            model_frame(vecs[i].keys);
            chk($sformatf("vec%0d_sw", i), 32'(button_sw), 32'(vecs[i].sw));
            chk($sformatf("vec%0d_pulses", i), 32'(p), 32'(vecs[i].pulses));
            chk($sformatf("vec%0d_code", i), 32'(key_code), 32'(vecs[i].code));
            chk($sformatf("vec%0d_multi", i), 32'(multi_key), 32'(vecs[i].multi));
        end

        k = 12'h001;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: k = '0;
                1: k = 12'(1) << $urandom_range(0, 11);
                2: k = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
                3: k = k & ~(12'(1) << $urandom_range(0, 11));
                default: ;
            endcase
            run_frame(k, p);
            model_frame(k);
            chk($sformatf("rnd%0d_sw", n), 32'(button_sw), 32'(m_sw));
            chk($sformatf("rnd%0d_pulses", n), 32'(p), 32'(m_pulse));
            chk($sformatf("rnd%0d_code", n), 32'(key_code), 32'(m_code));
            chk($sformatf("rnd%0d_multi", n), 32'(multi_key), 32'($countones(m_sw) > 1));
        end

        for (int n = 0; n < DB; n++) begin
            run_frame(12'h004, p);
            model_frame(12'h004);
        end
        chk("pre_rst_sw", 32'(button_sw), 32'h004);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_col", 32'(key_col), 32'b110);
        chk("mid_rst_sw", 32'(button_sw), 0);
        chk("mid_rst_code", 32'(key_code), 0);
        chk("mid_rst_valid", 32'(key_valid), 0);
        rst = 1'b0;
        model_reset();
        for (int n = 1; n <= DB; n++) begin
            run_frame(12'h004, p);
            model_frame(12'h004);
            chk($sformatf("post_rst_f%0d_sw", n), 32'(button_sw), n == DB ? 32'h004 : 32'h000);
            chk($sformatf("post_rst_f%0d_pulses", n), 32'(p), n == DB ? 1 : 0);
            chk($sformatf("post_rst_f%0d_code", n), 32'(key_code), n == DB ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
